// File: rtl/lcd_clock_display_if.sv
// LCD bus bundle: HD44780 8-bit write-only bus plus the end-of-frame pulse.
interface lcd_clock_display_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       frame_done;

    modport master (output lcd_e, output lcd_rs, output lcd_rw, output lcd_data, output frame_done);
    modport slave  (input  lcd_e, input  lcd_rs, input  lcd_rw, input  lcd_data, input  frame_done);
endinterface

// File: rtl/lcd_clock_display.sv
// Renders binary hour/min/sec as ASCII on line 1 of an HD44780 LCD (8-bit, write-only), endless refresh.
// Optional macro LCD_CLOCK_12H_EN selects the 12-hour "HH:MM:SS AM/PM" display.
module lcd_clock_display #(
    parameter int STEP_CYC  = 54000,
    parameter int E_CYC     = 30,
    parameter int PWR_STEPS = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [4:0]                 hour,
    input  logic [5:0]                 min,
    input  logic [5:0]                 sec,
    lcd_clock_display_if.master        lcd
);

`ifdef LCD_CLOCK_12H_EN
    localparam int N_CHARS = 11;
`else
    localparam int N_CHARS = 8;
`endif
    localparam int CNT_W = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
    localparam int IDX_W = $clog2(PWR_STEPS + 8);

    typedef enum logic [1:0] {PWR_WAIT, INIT, ADDR, CHAR} state_t;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd3:    return 8'h0C;
            3'd4:    return 8'h06;
            3'd5:    return 8'h01;
            default: return 8'h38;
        endcase
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   step_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [IDX_W-1:0]   wait_idx;
    logic [3:0]         char_idx;
    logic               writing;
    logic [4:0]         hour_s;
    logic [5:0]         min_s;
    logic [5:0]         sec_s;
    logic               e_r;
    logic               rs_r;
    logic               done_r;
    logic [7:0]         data_r;
    logic [4:0]         hour_disp;
    logic [7:0]         frame_chars [16];

    assign cnt_nxt = step_cnt + CNT_W'(1);

    // Character image of the whole line, derived only from the snapshot.
    always_comb begin
        for (int i = 0; i < 16; i++) frame_chars[i] = 8'h20;
`ifdef LCD_CLOCK_12H_EN
        if (hour_s == 5'd0)       hour_disp = 5'd12;
        else if (hour_s > 5'd12)  hour_disp = hour_s - 5'd12;
        else                      hour_disp = hour_s;
        frame_chars[9]  = (hour_s >= 5'd12) ? 8'h50 : 8'h41;
        frame_chars[10] = 8'h4D;
`else
        hour_disp = hour_s;
`endif
        frame_chars[0] = ascii_digit(tens_of({1'b0, hour_disp}));
        frame_chars[1] = ascii_digit(ones_of({1'b0, hour_disp}));
        frame_chars[2] = 8'h3A;
        frame_chars[3] = ascii_digit(tens_of(min_s));
        frame_chars[4] = ascii_digit(ones_of(min_s));
        frame_chars[5] = 8'h3A;
        frame_chars[6] = ascii_digit(tens_of(sec_s));
        frame_chars[7] = ascii_digit(ones_of(sec_s));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= PWR_WAIT;
            step_cnt <= '0;
            wait_idx <= '0;
            char_idx <= '0;
            writing  <= 1'b0;
            hour_s   <= '0;
            min_s    <= '0;
            sec_s    <= '0;
            e_r      <= 1'b0;
            rs_r     <= 1'b0;
            data_r   <= 8'h00;
            done_r   <= 1'b0;
        end else begin
            done_r <= (state == CHAR) && (char_idx == 4'(N_CHARS - 1)) &&
                      (step_cnt == CNT_W'(STEP_CYC - 2));
            if (step_cnt == CNT_W'(STEP_CYC - 1)) begin
                // Step boundary: select the next step and present its bus value on counter 0.
                step_cnt <= '0;
                e_r      <= 1'b0;
                case (state)
                    PWR_WAIT: begin
                        if (wait_idx == IDX_W'(PWR_STEPS - 1)) begin
                            state    <= INIT;
                            wait_idx <= '0;
                            rs_r     <= 1'b0;
                            data_r   <= init_cmd(3'd0);
                            writing  <= 1'b1;
                        end else begin
                            wait_idx <= wait_idx + IDX_W'(1);
                            writing  <= 1'b0;
                        end
                    end
                    INIT: begin
                        if (wait_idx == IDX_W'(6)) begin
                            state   <= ADDR;
                            hour_s  <= hour;
                            min_s   <= min;
                            sec_s   <= sec;
                            rs_r    <= 1'b0;
                            data_r  <= 8'h80;
                            writing <= 1'b1;
                        end else if (wait_idx == IDX_W'(5)) begin
                            wait_idx <= IDX_W'(6);
                            writing  <= 1'b0;
                        end else begin
                            wait_idx <= wait_idx + IDX_W'(1);
                            data_r   <= init_cmd(wait_idx[2:0] + 3'd1);
                            writing  <= 1'b1;
                        end
                    end
                    ADDR: begin
                        state    <= CHAR;
                        char_idx <= '0;
                        rs_r     <= 1'b1;
                        data_r   <= frame_chars[0];
                        writing  <= 1'b1;
                    end
                    default: begin
                        if (char_idx == 4'(N_CHARS - 1)) begin
                            state  <= ADDR;
                            hour_s <= hour;
                            min_s  <= min;
                            sec_s  <= sec;
                            rs_r   <= 1'b0;
                            data_r <= 8'h80;
                        end else begin
                            char_idx <= char_idx + 4'd1;
                            data_r   <= frame_chars[char_idx + 4'd1];
                        end
                        writing <= 1'b1;
                    end
                endcase
            end else begin
                step_cnt <= cnt_nxt;
                e_r      <= writing && (cnt_nxt >= CNT_W'(2)) && (cnt_nxt <= CNT_W'(E_CYC + 1));
            end
        end
    end

    assign lcd.lcd_e      = e_r;
    assign lcd.lcd_rs     = rs_r;
    assign lcd.lcd_rw     = 1'b0;
    assign lcd.lcd_data   = data_r;
    assign lcd.frame_done = done_r;

endmodule

// File: tb/tb_lcd_clock_display.sv
// Scoreboard bench for lcd_clock_display: expected bus writes are queued, a monitor pops them on each strobe.
module tb_lcd_clock_display;
    localparam int STEP_CYC  = 8;
    localparam int E_CYC     = 3;
    localparam int PWR_STEPS = 4;
`ifdef LCD_CLOCK_12H_EN
    localparam int FS = 12;
`else
    localparam int FS = 9;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;

    lcd_clock_display_if bus();

    lcd_clock_display #(.STEP_CYC(STEP_CYC), .E_CYC(E_CYC), .PWR_STEPS(PWR_STEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .hour  (hour),
        .min   (min),
        .sec   (sec),
        .lcd   (bus)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
        bit         last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frames   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input int gap, input bit last);
        exp_t e;
        e.rs = rs; e.data = data; e.gap = gap; e.last = last;
        sb.push_back(e);
    endtask

    // First command is checked against its absolute cycle after reset release.
    task automatic push_init();
        push(1'b0, 8'h38, 34, 1'b0);
        push(1'b0, 8'h38, 8, 1'b0);
        push(1'b0, 8'h38, 8, 1'b0);
        push(1'b0, 8'h0C, 8, 1'b0);
        push(1'b0, 8'h06, 8, 1'b0);
        push(1'b0, 8'h01, 8, 1'b0);
    endtask

    task automatic push_frame(input string s, input int gap80);
        push(1'b0, 8'h80, gap80, 1'b0);
        for (int i = 0; i < s.len(); i++) push(1'b1, s[i], 8, i == s.len() - 1);
    endtask

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc < target) begin
            @(negedge clk);
            g++;
            if (g > 3000) begin
                check("wait_cyc_timeout", cyc, target);
                break;
            end
        end
    endtask

    task automatic wait_frames(input int n);
        int g = 0;
        while (frames < n) begin
            @(negedge clk);
            g++;
            if (g > 3000) begin
                check("frame_timeout", frames, n);
                break;
            end
        end
    endtask

    // Monitor
    logic       prev_e;
    bit         seen_rise;
    int         rise_cyc;
    logic [8:0] rise_v, d1, d2;
    bit         last_pop_last;

    always @(negedge clk) begin
        if (!reset) begin
            prev_e = 1'b0; seen_rise = 0; last_pop_last = 0;
            d1 = '0; d2 = '0;
        end else begin
            if (bus.lcd_e && !prev_e) begin
                exp_t e;
                check("rw_low", int'(bus.lcd_rw), 0);
                check("setup_stable", int'(d2), int'({bus.lcd_rs, bus.lcd_data}));
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_strobe: got rs=%0b data=%0h, expected no strobe", bus.lcd_rs, bus.lcd_data);
                end else begin
                    e = sb.pop_front();
                    check("strobe_rs", int'(bus.lcd_rs), int'(e.rs));
                    check("strobe_data", int'(bus.lcd_data), int'(e.data));
                    if (!seen_rise) check("first_strobe_cycle", cyc, e.gap);
                    else            check("strobe_gap", cyc - rise_cyc, e.gap);
                    last_pop_last = e.last;
                end
                seen_rise = 1; rise_cyc = cyc; rise_v = {bus.lcd_rs, bus.lcd_data};
            end
            if (!bus.lcd_e && prev_e) begin
                check("e_width", cyc - rise_cyc, E_CYC);
                check("hold_stable", int'({bus.lcd_rs, bus.lcd_data}), int'(rise_v));
            end
            if (bus.frame_done) begin
                frames++;
                check("frame_done_after_last_char", int'(last_pop_last), 1);
                check("frame_done_cycle", cyc - rise_cyc, STEP_CYC - 1 - 2);
            end
            d2 = d1; d1 = {bus.lcd_rs, bus.lcd_data}; prev_e = bus.lcd_e;
        end
    end

    // Stimulus
    initial begin
`ifdef LCD_CLOCK_12H_EN
        hour = 5'd0;
`else
        hour = 5'd13;
`endif
        min = 6'd5; sec = 6'd9;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_e", int'(bus.lcd_e), 0);
        check("reset_rs", int'(bus.lcd_rs), 0);
        check("reset_rw", int'(bus.lcd_rw), 0);
        check("reset_data", int'(bus.lcd_data), 0);
        check("reset_frame_done", int'(bus.frame_done), 0);

        push_init();
`ifdef LCD_CLOCK_12H_EN
        push_frame("12:05:09 AM", 16);
        push_frame("12:05:10 AM", 8);
        push_frame("12:59:58 PM", 8);
        push_frame("11:63:00 PM", 8);
        push(1'b0, 8'h80, 8, 1'b0);
        push(1'b1, 8'h31, 8, 1'b0);
`else
        push_frame("13:05:09", 16);
        push_frame("13:05:10", 8);
        push_frame("23:59:58", 8);
        push_frame("31:63:00", 8);
        push(1'b0, 8'h80, 8, 1'b0);
        push(1'b1, 8'h33, 8, 1'b0);
`endif
        reset = 1'b1;

        // Mid-frame change (character index 4 of frame 1) lands in frame 2 only.
        wait_cyc(8 * (11 + 1 + 4) + 2);
        sec = 6'd10;
        wait_cyc(8 * (11 + FS) + 10);
`ifdef LCD_CLOCK_12H_EN
        hour = 5'd12;
`else
        hour = 5'd23;
`endif
        min = 6'd59; sec = 6'd58;
        wait_cyc(8 * (11 + 2 * FS) + 8);
`ifdef LCD_CLOCK_12H_EN
        hour = 5'd23;
`else
        hour = 5'd31;
`endif
        min = 6'd63; sec = 6'd0;

        wait_frames(4);
        begin
            int g = 0;
            while (!(bus.lcd_e && bus.lcd_rs)) begin
                @(negedge clk);
                g++;
                if (g > 200) begin
                    check("char_strobe_timeout", g, 0);
                    break;
                end
            end
        end
        #2 reset = 1'b0;
        #1;
        check("async_reset_e", int'(bus.lcd_e), 0);
        check("async_reset_data", int'(bus.lcd_data), 0);
        check("async_reset_rs", int'(bus.lcd_rs), 0);
        repeat (3) @(negedge clk);
        check("queue_empty_at_reset", sb.size(), 0);

        push_init();
`ifdef LCD_CLOCK_12H_EN
        push_frame("07:30:45 AM", 16);
`else
        push_frame("07:30:45", 16);
`endif
        hour = 5'd7; min = 6'd30; sec = 6'd45;
        reset = 1'b1;
        wait_frames(5);
        check("queue_empty_at_end", sb.size(), 0);
        check("frame_count", frames, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_clock_display.md
# lcd_clock_display

Downstream consumer of the time-of-day counter: takes binary `hour`/`min`/`sec` and continuously renders them as ASCII `HH:MM:SS` on line 1 of an HD44780-compatible character LCD in 8-bit, write-only mode. Owns LCD power-up wait, initialisation sequence and endless refresh; all bus timing is derived from the system clock by step counters.

## Interface
Parameters:
- `STEP_CYC`, 54000: clocks per LCD bus step (1 ms at 54 MHz); must be ≥ `E_CYC`+4.
- `E_CYC`, 30: clocks `lcd_e` is held high within a step.
- `PWR_STEPS`, 20: idle steps after reset before the first command.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `hour` in 5: binary hours.
- `min` in 6: binary minutes.
- `sec` in 6: binary seconds.
- `lcd_e` out 1: LCD enable strobe.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: tied 0 (write only).
- `lcd_data` out 8: LCD data bus.
- `frame_done` out 1: one-cycle pulse at the end of each complete refresh frame.

## Operation
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=8'h00, `frame_done`=0; FSM in PWR_WAIT, step counter 0.
- States: PWR_WAIT → INIT → ADDR → CHAR → ADDR …
- PWR_WAIT: `PWR_STEPS` idle steps, `lcd_e` low, then INIT.
- INIT: commands in order 8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01, one per step, `lcd_rs`=0; after 8'h01 one extra idle step (clear execution time); then ADDR.
- ADDR: snapshot `hour`,`min`,`sec` into internal registers on the first cycle of the step; write command 8'h80 (DDRAM line 1, column 0).
- CHAR: write characters index 0..7 with `lcd_rs`=1: H tens, H ones, ':' (8'h3A), M tens, M ones, ':', S tens, S ones. Digit = 8'h30 + value; tens = v/10, ones = v%10, computed from the snapshot only. Out-of-range inputs are rendered arithmetically (hour 31 → "31", min 63 → "63"); no clamping.
- After the last character step: `frame_done` pulses, return to ADDR (new snapshot). Refresh never stops.
- Reset asserted mid-operation: outputs drop to reset values immediately; sequence restarts from PWR_WAIT including the full power-up wait.

## Timing
- Each bus step is exactly `STEP_CYC` clocks; step counter runs 0..`STEP_CYC`-1.
- `lcd_rs`/`lcd_data` change only on step counter 0 and stay stable the whole step.
- Write step: `lcd_e`=1 for step counter values 2..`E_CYC`+1 inclusive, 0 otherwise (≥2 clocks setup, ≥`STEP_CYC`-`E_CYC`-2 hold).
- Idle steps: `lcd_e` stays 0; `lcd_data`/`lcd_rs` hold their previous values.
- Frame = 9 steps (12-hour build: 12 steps); `frame_done` is high on the cycle the last character step's counter equals `STEP_CYC`-1.
- First `lcd_e` rise after reset release: `PWR_STEPS`×`STEP_CYC`+2 clocks.
- Input changes during a frame do not affect that frame.

## Configuration
- `LCD_CLOCK_12H_EN` defined: 12-hour display `HH:MM:SS AM`/`PM` (11 characters: space 8'h20, 'A' 8'h41 or 'P' 8'h50, 'M' 8'h4D). Displayed hour: 0 → 12, 1–12 unchanged, 13–23 → hour−12; PM when hour ≥ 12. Hour tens shown as digit (leading '0' kept).
- Not defined: 24-hour `HH:MM:SS`, 8 characters, hour shown as-is.

## Test plan
Benches use `STEP_CYC`=8, `E_CYC`=3, `PWR_STEPS`=4.
- Reset, release → no `lcd_e` for 32 clocks; first strobe at clock 34 with `lcd_data`=8'h38, `lcd_rs`=0; next five commands 38,38,0C,06,01 one step apart, then one idle step.
- Inputs 13:05:09 (24-hour build) → bus sequence 80 (rs=0), then rs=1: 31 33 3A 30 35 3A 30 39; `frame_done` pulses once after 9 steps.
- Change `sec` 9→10 during CHAR index 4 → current frame still shows "09"; next frame shows "10".
- `LCD_CLOCK_12H_EN`, hour 0 → "12:..AM"; hour 12 → "12:..PM"; hour 23 → "11:..PM"; frame 12 steps.
- Assert reset during CHAR step with `lcd_e`=1 → `lcd_e`, `lcd_data`, `lcd_rs` go 0 in the same cycle; after release the full PWR_WAIT + INIT sequence repeats.
- Every strobe: `lcd_data`/`lcd_rs` stable from 2 clocks before `lcd_e` rise through the end of the step; `lcd_rw` always 0.
